rca_seq_chunked: RTL and testbench
==================================

Name: rca_seq_chunked

Overview:
- Parametrised successor to the 4-bit ripple-carry adder. Performs a WIDTH-bit add or subtract over multiple cycles, CHUNK bits per cycle, with the carry held in a register between chunks.
- Trades latency for a short ripple path per cycle.
- Sits between operand registers and the datapath result bus.
- Uses a start/busy/done handshake with registered, held results.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH.
- NCH (localparam) = WIDTH/CHUNK, number of compute cycles.

Ports:
- clk_in  input  1  clock; all logic on rising edge.
- rst_n_in  input  1  synchronous active-low reset.
- start_in  input  1  request; accepted only in IDLE.
- sub_in  input  1  0 = add, 1 = subtract; sampled with start.
- a_in  input  WIDTH  operand A; sampled with start.
- b_in  input  WIDTH  operand B; sampled with start.
- c_in  input  1  carry-in (add) or borrow-in (sub); sampled with start.
- busy_out  output  1  high while state is RUN.
- done_out  output  1  one-cycle pulse when the result becomes valid.
- sum_out  output  WIDTH  result; held until the next completion.
- carry_out  output  1  carry out of MSB; in sub mode, 1 means no borrow.
- overflow_out  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n_in low at an edge):
  - State goes to IDLE; chunk index and carry register cleared.
  - busy_out, done_out, sum_out, carry_out, overflow_out all 0.
  - Reset during RUN aborts the operation: no done pulse, outputs return to 0.
- States:
  - IDLE: start_in high at an edge latches a_in, b_in, c_in and sub_in. Next state RUN, idx = 0.
  - RUN: each cycle adds chunk idx of A to chunk idx of B', plus the carry register. The chunk sum goes to the internal result register; the carry register is updated. If idx = NCH-1, next state DONE; otherwise idx+1.
  - DONE: lasts exactly one cycle with done_out = 1. Always returns to IDLE.
- Operand preparation: B' = sub ? ~B : B. Initial carry = sub ? ~c_in : c_in, so sub computes A - B - c_in.
- Output update: sum_out, carry_out and overflow_out are written only on the RUN -> DONE edge. They are stable from the done_out cycle until the next completion and never show partial sums.
- Overflow: the carry into bit WIDTH-1 is taken inside the final chunk computation.
- Latency:
  - Start accepted at edge E. busy_out is high for cycles E+1 .. E+NCH.
  - done_out is high in cycle E+NCH+1. The next start is accepted at earliest at edge E+NCH+2 (IDLE).
  - Throughput is 1 operation per NCH+2 cycles.
- start_in while in RUN or DONE is ignored: no queuing, latched operands unaffected.
- Operand inputs may change freely after the accepting edge.
- CHUNK = WIDTH (NCH = 1): one RUN cycle, behaviour otherwise identical.
- All arithmetic is modulo 2^WIDTH. Carry chain width is exactly CHUNK+1 per cycle.

Test Plan:
- WIDTH=16, CHUNK=4, add: a=0xFFFF, b=0x0001, c=0.
  - busy for 4 cycles; done 5 cycles after the start edge.
  - sum=0x0000, carry=1, ovf=0.
- Add: a=0x7FFF, b=0x0001, c=0 -> sum=0x8000, carry=0, ovf=1. Then a=0x1234, b=0x4321, c=1 -> sum=0x5556, carry=0, ovf=0.
- Sub: a=0x0005, b=0x0007, c=0 -> sum=0xFFFE, carry=0, ovf=0. Then a=0x8000, b=0x0001, c=0 -> sum=0x7FFF, carry=1, ovf=1.
- Pulse start_in with different operands during RUN and during DONE -> ignored; result matches the first operands.
- Start in the IDLE cycle immediately after done -> accepted; the previous result holds until the new done.
- Handshake/reset edge cases:
  - Drive rst_n_in low in the 2nd RUN cycle -> all outputs 0 next cycle, no done pulse. A following add of 0x00FF+0x0001 gives 0x0100.
  - Repeat with CHUNK=16 (done 2 cycles after start) and CHUNK=1 (done 17 cycles after start); random add/sub results match a reference model.

Source files
------------

// File: rtl/rca_seq_chunked.sv
// Multi-cycle ripple-carry adder/subtractor: CHUNK bits per cycle, carry held
// in a register between chunks, start/busy/done handshake with held results.
module rca_seq_chunked #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic             sub_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             overflow_out
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [CHUNK:0]   csum_d;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d;
    logic             last_d;

    // Operands shift right one chunk per cycle, so the active chunk is always
    // the low CHUNK bits; the result fills from the top and lands aligned.
    always_comb begin
        csum_d = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, carry_q};
        res_d  = (res_q >> CHUNK) | (WIDTH'(csum_d[CHUNK-1:0]) << (WIDTH - CHUNK));
        // Carry into the chunk MSB recovered from its sum bit.
        ovf_d  = (a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ csum_d[CHUNK-1]) ^ csum_d[CHUNK];
        last_d = (idx_q == IW'(NCH - 1));
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_in) begin
                        a_q     <= a_in;
                        b_q     <= sub_in ? ~b_in : b_in;
                        carry_q <= sub_in ? ~c_in : c_in;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    res_q   <= res_d;
                    carry_q <= csum_d[CHUNK];
                    if (last_d) begin
                        sum_q   <= res_d;
                        cout_q  <= csum_d[CHUNK];
                        ovf_q   <= ovf_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_out     = busy_q;
    assign done_out     = done_q;
    assign sum_out      = sum_q;
    assign carry_out    = cout_q;
    assign overflow_out = ovf_q;

endmodule

// File: tb/tb_rca_seq_chunked.sv
// Bench for rca_seq_chunked: three instances (CHUNK = 4, 1, 16) checked against
// fixed vectors, handshake/reset sequences and a signed-arithmetic model.
module tb_rca_seq_chunked;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start;
    logic        sub_i;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        c_i;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [15:0] sum_o [3];
    logic [2:0]  carry_o;
    logic [2:0]  ovf_o;

    int n_pass  = 0;
    int n_total = 0;
    int nch [3] = '{4, 1, 16};
    logic [15:0] prev [3];

    always #5 clk = ~clk;

    rca_seq_chunked #(.WIDTH(16), .CHUNK(4)) dut_c4 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start[0]), .sub_in(sub_i),
        .a_in(a_i), .b_in(b_i), .c_in(c_i), .busy_out(busy[0]), .done_out(done[0]),
        .sum_out(sum_o[0]), .carry_out(carry_o[0]), .overflow_out(ovf_o[0]));

    rca_seq_chunked #(.WIDTH(16), .CHUNK(16)) dut_c16 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start[1]), .sub_in(sub_i),
        .a_in(a_i), .b_in(b_i), .c_in(c_i), .busy_out(busy[1]), .done_out(done[1]),
        .sum_out(sum_o[1]), .carry_out(carry_o[1]), .overflow_out(ovf_o[1]));

    rca_seq_chunked #(.WIDTH(16), .CHUNK(1)) dut_c1 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start[2]), .sub_in(sub_i),
        .a_in(a_i), .b_in(b_i), .c_in(c_i), .busy_out(busy[2]), .done_out(done[2]),
        .sum_out(sum_o[2]), .carry_out(carry_o[2]), .overflow_out(ovf_o[2]));

    typedef struct {
        bit          sub;
        logic [15:0] a;
        logic [15:0] b;
        bit          c;
        logic [15:0] sum;
        bit          carry;
        bit          ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic on the operands' unsigned and signed values.
    function automatic void model(input bit s, input logic [15:0] a, input logic [15:0] b,
                                  input bit c, output logic [15:0] sum, output bit co,
                                  output bit ov);
        int unsigned ua = a;
        int unsigned ub = b;
        int unsigned full;
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int sres;
        if (s) begin
            full = ua + (32'hFFFF - ub) + (c ? 0 : 1);
            sres = sa - sb - int'(c);
        end else begin
            full = ua + ub + int'(c);
            sres = sa + sb + int'(c);
        end
        sum = full[15:0];
        co  = full[16];
        ov  = (sres > 32767) || (sres < -32768);
    endfunction

    task automatic start_op(input int d, input bit s, input logic [15:0] a,
                            input logic [15:0] b, input bit c);
        @(negedge clk);
        sub_i = s; a_i = a; b_i = b; c_i = c;
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        sub_i = 1'($urandom); a_i = 16'($urandom); b_i = 16'($urandom); c_i = 1'($urandom);
    endtask

    // Counts edges until done is seen at a negedge; bounded.
    task automatic wait_done(input int d, input logic [15:0] hold_val, output int edges,
                             output bit busy_ok, output bit hold_ok);
        edges = 0; busy_ok = 1'b1; hold_ok = 1'b1;
        @(negedge clk);
        while (!done[d] && edges < 200) begin
            if (!busy[d]) busy_ok = 1'b0;
            if (sum_o[d] !== hold_val) hold_ok = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic run_check(input int d, input bit s, input logic [15:0] a,
                             input logic [15:0] b, input bit c, input logic [15:0] es,
                             input bit ec, input bit eo, input string tag, input bit tail);
        int edges;
        bit busy_ok, hold_ok;
        start_op(d, s, a, b, c);
        wait_done(d, prev[d], edges, busy_ok, hold_ok);
        check({tag, " latency"}, edges, nch[d]);
        check({tag, " busy_while_run"}, {31'd0, busy_ok}, 1);
        check({tag, " result_held"}, {31'd0, hold_ok}, 1);
        check({tag, " busy_at_done"}, {31'd0, busy[d]}, 0);
        check({tag, " sum"}, {16'd0, sum_o[d]}, {16'd0, es});
        check({tag, " carry"}, {31'd0, carry_o[d]}, {31'd0, ec});
        check({tag, " ovf"}, {31'd0, ovf_o[d]}, {31'd0, eo});
        prev[d] = es;
        if (tail) begin
            @(negedge clk);
            check({tag, " done_pulse"}, {30'd0, busy[d], done[d]}, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] es;
        bit ec, eo;
        int edges;
        bit busy_ok, hold_ok, saw_done;

        vecs[0] = '{0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0};
        vecs[1] = '{0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1};
        vecs[2] = '{0, 16'h1234, 16'h4321, 1, 16'h5556, 0, 0};
        vecs[3] = '{1, 16'h0005, 16'h0007, 0, 16'hFFFE, 0, 0};
        vecs[4] = '{1, 16'h8000, 16'h0001, 0, 16'h7FFF, 1, 1};
        vecs[5] = '{1, 16'h0000, 16'h0000, 1, 16'hFFFF, 0, 0};
        vecs[6] = '{0, 16'h8000, 16'h8000, 0, 16'h0000, 1, 1};
        vecs[7] = '{0, 16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 1, 0};

        rst_n = 1'b0; start = '0; sub_i = 1'b0; a_i = '0; b_i = '0; c_i = 1'b0;
        for (int d = 0; d < 3; d++) prev[d] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_state dut%0d", d),
                  {13'd0, busy[d], done[d], carry_o[d], sum_o[d]}, 0);
            check($sformatf("reset_ovf dut%0d", d), {31'd0, ovf_o[d]}, 0);
        end
        rst_n = 1'b1;

        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 8; i++)
                run_check(d, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sum,
                          vecs[i].carry, vecs[i].ovf, $sformatf("vec%0d dut%0d", i, d), 1);

        // start pulses during RUN and DONE must be ignored
        start_op(0, 0, 16'h1111, 16'h2222, 0);
        @(negedge clk);
        sub_i = 1'b1; a_i = 16'hAAAA; b_i = 16'h5555; c_i = 1'b1; start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        wait_done(0, prev[0], edges, busy_ok, hold_ok);
        check("ign_run latency", edges, 3);
        check("ign_run sum", {16'd0, sum_o[0]}, 32'h3333);
        check("ign_run flags", {30'd0, carry_o[0], ovf_o[0]}, 0);
        sub_i = 1'b1; a_i = 16'h0F0F; b_i = 16'h0101; start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (busy[0] || done[0] || sum_o[0] !== 16'h3333) saw_done = 1'b1;
        end
        check("ign_done no_restart", {31'd0, saw_done}, 0);
        prev[0] = 16'h3333;

        // back-to-back: next start in the IDLE cycle right after done
        for (int d = 0; d < 3; d++) begin
            run_check(d, 0, 16'h0001, 16'h0002, 0, 16'h0003, 0, 0,
                      $sformatf("b2b_first dut%0d", d), 0);
            run_check(d, 0, 16'h0010, 16'h0020, 0, 16'h0030, 0, 0,
                      $sformatf("b2b_second dut%0d", d), 1);
        end

        // reset in the second RUN cycle aborts the operation
        start_op(0, 0, 16'h1234, 16'h1111, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort outputs", {13'd0, busy[0], done[0], carry_o[0], sum_o[0]}, 0);
        check("abort ovf", {31'd0, ovf_o[0]}, 0);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done[0] || busy[0]) saw_done = 1'b1;
        end
        check("abort no_done", {31'd0, saw_done}, 0);
        for (int d = 0; d < 3; d++) prev[d] = '0;
        run_check(0, 0, 16'h00FF, 16'h0001, 0, 16'h0100, 0, 0, "after_abort", 1);

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 15; i++) begin
                bit s, c;
                logic [15:0] a, b;
                s = 1'($urandom); c = 1'($urandom);
                a = 16'($urandom); b = 16'($urandom);
                model(s, a, b, c, es, ec, eo);
                run_check(d, s, a, b, c, es, ec, eo, $sformatf("rand%0d dut%0d", i, d), 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
